ppd_commutator_ctrl: RTL and testbench

Input commutator and scheduler for the polyphase decimation filter (filt_ppd). It accepts one input sample stream and steers each sample into one of gp_nr_phases branch delay lines by driving their per-branch enables. It also tracks when every branch delay line has been primed and issues one decimated-output strobe per completed frame for the downstream branch-sum adder.

---
 rtl/ppd_commutator_ctrl.sv | 101 ++++++++++
 tb/tb_ppd_commutator_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ppd_commutator_ctrl.sv
// Input commutator for the polyphase decimator: routes samples to branches in the
// order M-1..0, pulses frame_done per completed frame and out_valid once all branches are primed.
module ppd_commutator_ctrl #(
    parameter int gp_data_width = 8,
    parameter int gp_nr_phases  = 4,
    parameter int gp_nr_stages  = 4
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_an,
    input  logic                                      i_clr,
    input  logic                                      i_valid,
    input  logic [gp_data_width-1:0]                  i_data,
    output logic [gp_data_width-1:0]                  o_data,
    output logic [gp_nr_phases-1:0]                   o_branch_ena,
    output logic [((gp_nr_phases > 2) ? $clog2(gp_nr_phases) : 1)-1:0] o_phase,
    output logic                                      o_frame_done,
    output logic                                      o_primed,
    output logic                                      o_out_valid,
    output logic [1:0]                                o_state
);

    localparam int PW = (gp_nr_phases > 2) ? $clog2(gp_nr_phases) : 1;
    localparam int FW = $clog2(gp_nr_stages + 1);
    localparam logic [PW-1:0]           PH_LAST  = PW'(gp_nr_phases - 1);
    localparam logic [FW-1:0]           FRM_FULL = FW'(gp_nr_stages);
    localparam logic [gp_nr_phases-1:0] ENA_ONE  = {{(gp_nr_phases-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   r_phase;
    logic [FW-1:0]   r_frm;
    logic            frame_end;
    logic            frm_hit;

    // The frame counter reaches N on exactly the frame end that finds it at N-1.
    assign frame_end = i_valid && (r_phase == '0);
    assign frm_hit   = frame_end && (r_frm == FRM_FULL - FW'(1));
    assign o_state   = state;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (i_clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_valid) state_nxt = FILL;
                FILL:    if (frm_hit) state_nxt = RUN;
                RUN:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) state <= IDLE;
        else           state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            r_phase      <= PH_LAST;
            r_frm        <= '0;
            o_data       <= '0;
            o_branch_ena <= '0;
            o_phase      <= '0;
            o_frame_done <= 1'b0;
            o_primed     <= 1'b0;
            o_out_valid  <= 1'b0;
        end else if (i_clr) begin
            // Soft clear drops any coincident sample; o_data intentionally keeps its value.
            r_phase      <= PH_LAST;
            r_frm        <= '0;
            o_branch_ena <= '0;
            o_frame_done <= 1'b0;
            o_primed     <= 1'b0;
            o_out_valid  <= 1'b0;
        end else if (i_valid) begin
            o_data       <= i_data;
            o_branch_ena <= ENA_ONE << r_phase;
            o_phase      <= r_phase;
            o_frame_done <= frame_end;
            o_primed     <= o_primed || frm_hit;
            o_out_valid  <= frame_end && (o_primed || frm_hit);
            r_phase      <= (r_phase == '0) ? PH_LAST : r_phase - PW'(1);
            if (frame_end && (r_frm != FRM_FULL))
                r_frm <= r_frm + FW'(1);
        end else begin
            o_branch_ena <= '0;
            o_frame_done <= 1'b0;
            o_out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ppd_commutator_ctrl.sv
// Scoreboard bench for ppd_commutator_ctrl: a sample-count reference model pushes expected
// branch writes; a monitor pops them whenever the DUT raises a branch enable.
module tb_ppd_commutator_ctrl;

    localparam int DW = 8;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int PW = 2;

    logic          i_clk = 1'b0;
    logic          i_rst_an;
    logic          i_clr;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic [DW-1:0] o_data;
    logic [M-1:0]  o_branch_ena;
    logic [PW-1:0] o_phase;
    logic          o_frame_done;
    logic          o_primed;
    logic          o_out_valid;
    logic [1:0]    o_state;

    ppd_commutator_ctrl #(.gp_data_width(DW), .gp_nr_phases(M), .gp_nr_stages(N)) dut (
        .i_clk        (i_clk),
        .i_rst_an     (i_rst_an),
        .i_clr        (i_clr),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_data       (o_data),
        .o_branch_ena (o_branch_ena),
        .o_phase      (o_phase),
        .o_frame_done (o_frame_done),
        .o_primed     (o_primed),
        .o_out_valid  (o_out_valid),
        .o_state      (o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [M-1:0]  ena;
        int            phase;
        bit            fd;
        bit            primed;
        bit            ov;
        int            state;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: everything follows from the count of samples accepted since reset/clear.
    int            m_count;
    bit            m_primed;
    int            m_state;
    logic [DW-1:0] m_last_data;
    int            n_ov_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic model_reset(input bit keep_data);
        m_count  = 0;
        m_primed = 0;
        m_state  = 0;
        if (!keep_data) m_last_data = '0;
    endtask

    task automatic drive(input bit v, input bit c, input logic [DW-1:0] d);
        exp_t e;
        int   pos;
        @(negedge i_clk);
        i_valid = v;
        i_clr   = c;
        i_data  = d;
        if (c) begin
            model_reset(1);
        end else if (v) begin
            pos       = m_count % M;
            m_count   = m_count + 1;
            if (m_count / M >= N) m_primed = 1;
            m_state   = m_primed ? 2 : 1;
            m_last_data = d;
            e.data    = d;
            e.phase   = M - 1 - pos;
            e.ena     = M'(1) << e.phase;
            e.fd      = (pos == M - 1);
            e.primed  = m_primed;
            e.ov      = e.fd && m_primed;
            e.state   = m_state;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (o_branch_ena != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(o_branch_ena), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data",       32'(o_data),       32'(e.data));
                    check("branch_ena", 32'(o_branch_ena), 32'(e.ena));
                    check("phase",      32'(o_phase),      32'(e.phase));
                    check("frame_done", 32'(o_frame_done), 32'(e.fd));
                    check("primed",     32'(o_primed),     32'(e.primed));
                    check("out_valid",  32'(o_out_valid),  32'(e.ov));
                    check("state",      32'(o_state),      32'(e.state));
                    if (o_out_valid) n_ov_seen++;
                end
            end else begin
                check("idle_frame_done", 32'(o_frame_done), 0);
                check("idle_out_valid",  32'(o_out_valid),  0);
                check("idle_primed",     32'(o_primed),     32'(m_primed));
                check("idle_state",      32'(o_state),      32'(m_state));
                check("idle_data_hold",  32'(o_data),       32'(m_last_data));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ov_before;
        i_rst_an = 1'b0;
        i_clr    = 1'b0;
        i_valid  = 1'b0;
        i_data   = '0;
        model_reset(0);
        n_ov_seen = 0;
        #12;
        check("rst_data",   32'(o_data), 0);
        check("rst_ena",    32'(o_branch_ena), 0);
        check("rst_phase",  32'(o_phase), 0);
        check("rst_fd",     32'(o_frame_done), 0);
        check("rst_primed", 32'(o_primed), 0);
        check("rst_ov",     32'(o_out_valid), 0);
        check("rst_state",  32'(o_state), 0);
        @(negedge i_clk);
        i_rst_an = 1'b1;

        // First frame 10..13, then fill to 16 samples total.
        for (int i = 0; i < 16; i++) drive(1, 0, DW'(10 + i));
        drive(0, 0, 8'h00);

        // Gapped input over 8 samples.
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, DW'(100 + i));
            drive(0, 0, DW'(200 + i));
        end

        // Soft clear coincident with a valid sample just after phase 2 was written.
        while (m_count % M != 2) drive(1, 0, DW'($urandom));
        drive(1, 1, 8'h5A);
        for (int i = 0; i < 18; i++) drive(1, 0, DW'($urandom));

        // Async reset between edges while running.
        @(posedge i_clk);
        #3;
        i_rst_an = 1'b0;
        i_valid  = 1'b0;
        model_reset(0);
        #1;
        check("arst_data",   32'(o_data), 0);
        check("arst_ena",    32'(o_branch_ena), 0);
        check("arst_fd",     32'(o_frame_done), 0);
        check("arst_primed", 32'(o_primed), 0);
        check("arst_ov",     32'(o_out_valid), 0);
        check("arst_state",  32'(o_state), 0);
        @(negedge i_clk);
        i_rst_an = 1'b1;

        // Saturation: 100 back-to-back frames, one out_valid per primed frame.
        ov_before = n_ov_seen;
        for (int i = 0; i < 100 * M; i++) drive(1, 0, DW'($urandom));
        drive(0, 0, 8'h00);
        @(posedge i_clk);
        #2;
        check("sat_ov_count", 32'(n_ov_seen - ov_before), 32'(100 - N + 1));
        check("sat_frm",      32'(dut.r_frm), 32'(N));

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 400; i++)
            drive(($urandom % 4) != 0, ($urandom % 60) == 0, DW'($urandom));
        drive(0, 0, 8'h00);
        drive(0, 0, 8'h00);
        @(posedge i_clk);
        #2;
        check("sb_drain", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
